// File: rtl/l2_mem_arbiter_pkg.sv
// Shared types and constants for the L2 instruction/data memory-port arbiter.
// Optional feature macro: L2_MEM_ARB_RR_EN (round-robin arbitration).
package l2_mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, REL} arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

endpackage

// File: rtl/l2_mem_arbiter_pick.sv
// Combinational winner selection between the I-side and D-side requesters.
// L2_MEM_ARB_RR_EN selects round-robin; otherwise fixed D priority with a starvation cap.
module l2_arb_pick
  import l2_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       pend_i,
  input  logic       pend_d,
  input  logic       last_grant,
  input  logic [3:0] starve_cnt,
  output logic       gnt_vld,
  output logic       winner
);

  always_comb begin
    gnt_vld = pend_i | pend_d;
    winner  = pend_d ? GNT_D : GNT_I;
    if (pend_i && pend_d) begin
`ifdef L2_MEM_ARB_RR_EN
      winner = ~last_grant;
`else
      // I gets one guaranteed slot after STARVE_LIMIT back-to-back D wins
      if (starve_cnt == 4'(STARVE_LIMIT)) winner = GNT_I;
`endif
    end
  end

`ifdef L2_MEM_ARB_RR_EN
  logic [3:0] unused_cnt;
  assign unused_cnt = starve_cnt;
`else
  logic unused_lg;
  assign unused_lg = last_grant;
`endif

endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares one line-wide memory port between the I-side and D-side L2 caches.
// Policy lives in l2_arb_pick; L2_MEM_ARB_RR_EN switches it to round-robin.
module l2_mem_arbiter
  import l2_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LINE_W       = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e state, nxt;
  logic [3:0] starve_cnt;
  logic       last_grant;
  logic       pend_i, pend_d, gnt_vld, winner;
  logic       sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  assign pend_i = i_read | i_write;
  assign pend_d = d_read | d_write;

  l2_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .pend_i     (pend_i),
    .pend_d     (pend_d),
    .last_grant (last_grant),
    .starve_cnt (starve_cnt),
    .gnt_vld    (gnt_vld),
    .winner     (winner)
  );

  // Write takes precedence if a requester illegally raises both
  assign sel_wr    = (winner == GNT_D) ? d_write : i_write;
  assign sel_rd    = ((winner == GNT_D) ? d_read : i_read) & ~sel_wr;
  assign sel_addr  = (winner == GNT_D) ? d_addr  : i_addr;
  assign sel_wdata = (winner == GNT_D) ? d_wdata : i_wdata;

  always_ff @(posedge clk) begin
    if (proc_reset) state <= IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:           if (gnt_vld) nxt = (winner == GNT_D) ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (mem_ready) nxt = REL;
      REL:            nxt = IDLE;
      default:        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      starve_cnt <= 4'd0;
      last_grant <= GNT_D;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: if (gnt_vld) begin
          mem_read   <= sel_rd;
          mem_write  <= sel_wr;
          mem_addr   <= sel_addr;
          mem_wdata  <= sel_wdata;
          last_grant <= winner;
          if (winner == GNT_I)  starve_cnt <= 4'd0;
          else if (pend_i)      starve_cnt <= starve_cnt + 4'd1;
        end
        BUSY_I, BUSY_D: if (mem_ready) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (state == BUSY_I) begin
            i_ready <= 1'b1;
            if (mem_read) i_rdata <= mem_rdata;
          end else begin
            d_ready <= 1'b1;
            if (mem_read) d_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
